// File: rtl/vfr_control_packet_decoder.sv
// Splits a VIP stream: video packets are forwarded combinationally and control packets are decoded into width/height/interlace.
// Define VFR_DECODER_USER_PKT_PASS_EN to forward non-video user packets instead of dropping them.
module vfr_control_packet_decoder #(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        din_valid,
  input  logic                                        din_sop,
  input  logic                                        din_eop,
  input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
  output logic                                        din_ready,
  input  logic                                        dout_ready,
  output logic                                        dout_valid,
  output logic                                        dout_sop,
  output logic                                        dout_eop,
  output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
  output logic [15:0]                                 width,
  output logic [15:0]                                 height,
  output logic [3:0]                                  interlaced,
  output logic                                        ctrl_valid,
  output logic                                        ctrl_error
);

  localparam logic [3:0] NEED_BEATS = 4'((9 + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT);
  localparam logic [3:0] CNT_MAX    = 4'hF;

`ifdef VFR_DECODER_USER_PKT_PASS_EN
  typedef enum logic [1:0] {IDLE, VIDEO, CONTROL} state_t;
`else
  typedef enum logic [1:0] {IDLE, VIDEO, CONTROL, DISCARD} state_t;
`endif

  state_t      state_reg, state_next;
  logic [3:0]  beat_cnt_reg, beat_cnt_next, beat_cnt_inc;
  logic [35:0] shadow_reg, shadow_next, shadow_wr;
  logic [15:0] width_reg, height_reg;
  logic [3:0]  interlaced_reg;
  logic        ctrl_valid_reg, ctrl_valid_next;
  logic        ctrl_error_reg, ctrl_error_next;

  logic [3:0]  sop_type;
  logic        pass_type;
  logic        ctrl_type;
  logic [15:0] wr_width, wr_height;
  logic [3:0]  wr_interlace;
  logic        pkt_complete;

  assign sop_type  = din_data[3:0];
  assign ctrl_type = (sop_type == 4'hF);
`ifdef VFR_DECODER_USER_PKT_PASS_EN
  assign pass_type = (sop_type != 4'hF);
`else
  assign pass_type = (sop_type == 4'h0);
`endif

  assign dout_data = din_data;
  assign dout_sop  = din_sop;
  assign dout_eop  = din_eop;

  assign beat_cnt_inc = (beat_cnt_reg == CNT_MAX) ? CNT_MAX : beat_cnt_reg + 4'd1;

  // Shadow as it would look after the current payload beat; nibble k lives at [4k +: 4].
  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_nib
      localparam int BEAT = gi / SYMBOLS_PER_BEAT;
      localparam int SYM  = gi % SYMBOLS_PER_BEAT;
      assign shadow_wr[gi*4 +: 4] = (beat_cnt_reg == 4'(BEAT)) ?
                                    din_data[SYM*BITS_PER_SYMBOL +: 4] :
                                    shadow_reg[gi*4 +: 4];
    end
  endgenerate

  // First nibble on the wire is the most significant one.
  assign wr_width     = {shadow_wr[3:0],   shadow_wr[7:4],   shadow_wr[11:8],  shadow_wr[15:12]};
  assign wr_height    = {shadow_wr[19:16], shadow_wr[23:20], shadow_wr[27:24], shadow_wr[31:28]};
  assign wr_interlace = shadow_wr[35:32];
  assign pkt_complete = (beat_cnt_inc >= NEED_BEATS) && (|wr_width) && (|wr_height);

  always_comb begin
    state_next      = state_reg;
    beat_cnt_next   = beat_cnt_reg;
    shadow_next     = shadow_reg;
    ctrl_valid_next = 1'b0;
    ctrl_error_next = 1'b0;
    din_ready       = 1'b0;
    dout_valid      = 1'b0;

    if (din_valid && din_sop) begin
      // A sop is always decoded as from IDLE; accepting it aborts whatever was open.
      if (pass_type) begin
        din_ready  = dout_ready;
        dout_valid = 1'b1;
        if (dout_ready) state_next = din_eop ? IDLE : VIDEO;
      end else if (ctrl_type) begin
        din_ready     = 1'b1;
        beat_cnt_next = 4'd0;
        state_next    = din_eop ? IDLE : CONTROL;
        if (din_eop) ctrl_error_next = 1'b1;
      end
`ifdef VFR_DECODER_USER_PKT_PASS_EN
`else
      else begin
        din_ready  = 1'b1;
        state_next = din_eop ? IDLE : DISCARD;
      end
`endif
      if (din_ready && (state_reg == CONTROL)) ctrl_error_next = 1'b1;
    end else begin
      case (state_reg)
        IDLE: din_ready = 1'b1;
        VIDEO: begin
          din_ready  = dout_ready;
          dout_valid = din_valid;
          if (din_valid && dout_ready && din_eop) state_next = IDLE;
        end
        CONTROL: begin
          din_ready = 1'b1;
          if (din_valid) begin
            beat_cnt_next = beat_cnt_inc;
            shadow_next   = shadow_wr;
            if (din_eop) begin
              state_next      = IDLE;
              ctrl_valid_next = pkt_complete;
              ctrl_error_next = !pkt_complete;
            end
          end
        end
`ifdef VFR_DECODER_USER_PKT_PASS_EN
`else
        DISCARD: begin
          din_ready = 1'b1;
          if (din_valid && din_eop) state_next = IDLE;
        end
`endif
        default: state_next = IDLE;
      endcase
    end

    if (rst) begin
      din_ready  = 1'b0;
      dout_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      beat_cnt_reg   <= 4'd0;
      shadow_reg     <= 36'd0;
      width_reg      <= 16'd0;
      height_reg     <= 16'd0;
      interlaced_reg <= 4'd0;
      ctrl_valid_reg <= 1'b0;
      ctrl_error_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_cnt_reg   <= beat_cnt_next;
      shadow_reg     <= shadow_next;
      ctrl_valid_reg <= ctrl_valid_next;
      ctrl_error_reg <= ctrl_error_next;
      if (ctrl_valid_next) begin
        width_reg      <= wr_width;
        height_reg     <= wr_height;
        interlaced_reg <= wr_interlace;
      end
    end
  end

  assign width      = width_reg;
  assign height     = height_reg;
  assign interlaced = interlaced_reg;
  assign ctrl_valid = ctrl_valid_reg;
  assign ctrl_error = ctrl_error_reg;

endmodule

// File: tb/tb_vfr_control_packet_decoder.sv
// Randomised bench for vfr_control_packet_decoder against a packet-level reference model.
// Honours VFR_DECODER_USER_PKT_PASS_EN when deciding which packets are expected on the source side.
module tb_vfr_control_packet_decoder;
  localparam int BPS = 8;
  localparam int SPB = 3;
  localparam int DW  = BPS * SPB;
  localparam int NEED = (9 + SPB - 1) / SPB;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [DW-1:0] din_data = '0;
  logic          din_ready;
  logic          dout_ready = 1'b1;
  logic          dout_valid, dout_sop, dout_eop;
  logic [DW-1:0] dout_data;
  logic [15:0]   width, height;
  logic [3:0]    interlaced;
  logic          ctrl_valid, ctrl_error;

  always #5 clk = ~clk;

  vfr_control_packet_decoder #(.BITS_PER_SYMBOL(BPS), .SYMBOLS_PER_BEAT(SPB)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop), .din_data(din_data),
    .din_ready(din_ready), .dout_ready(dout_ready),
    .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_data(dout_data),
    .width(width), .height(height), .interlaced(interlaced),
    .ctrl_valid(ctrl_valid), .ctrl_error(ctrl_error)
  );

  beat_t pkt_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_tests = 0, n_fail = 0;
  int    cv_cnt = 0, ce_cnt = 0;
  bit    both_seen = 1'b0;
  int    exp_nv = 0, exp_ne = 0;
  logic [15:0] exp_w = '0, exp_h = '0;
  logic [3:0]  exp_il = '0;
  bit    ctrl_open = 1'b0;
  int    chk_idx = 0;
  int    pkt_no = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && dout_ready) obs_q.push_back({dout_sop, dout_eop, dout_data});
      if (ctrl_valid) cv_cnt++;
      if (ctrl_error) ce_cnt++;
      if (ctrl_valid && ctrl_error) both_seen = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  function automatic bit passes(input logic [3:0] t);
`ifdef VFR_DECODER_USER_PKT_PASS_EN
    return t != 4'hF;
`else
    return t == 4'h0;
`endif
  endfunction

  // Video or user packet: header beat plus npix data beats.
  task automatic build_stream(input logic [3:0] t, input int npix, input bit trunc);
    beat_t b;
    pkt_q.delete();
    b.sop = 1'b1; b.eop = (npix == 0) && !trunc; b.data = DW'($urandom); b.data[3:0] = t;
    pkt_q.push_back(b);
    for (int i = 0; i < npix; i++) begin
      b.sop = 1'b0; b.eop = (i == npix - 1) && !trunc; b.data = DW'($urandom);
      pkt_q.push_back(b);
    end
    if (ctrl_open) exp_ne++;
    ctrl_open = 1'b0;
    if (passes(t)) foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
  endtask

  // Control packet: nibbles w3..w0 h3..h0 int, then random filler.
  task automatic build_ctrl(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il,
                            input int npay, input bit trunc);
    logic [3:0] nib[$];
    beat_t b;
    for (int i = 3; i >= 0; i--) nib.push_back(w[i*4 +: 4]);
    for (int i = 3; i >= 0; i--) nib.push_back(h[i*4 +: 4]);
    nib.push_back(il);
    while (nib.size() < npay * SPB) nib.push_back(4'($urandom));
    pkt_q.delete();
    b.sop = 1'b1; b.eop = (npay == 0) && !trunc; b.data = DW'($urandom); b.data[3:0] = 4'hF;
    pkt_q.push_back(b);
    for (int bb = 0; bb < npay; bb++) begin
      b.sop = 1'b0; b.eop = (bb == npay - 1) && !trunc; b.data = DW'($urandom);
      for (int s = 0; s < SPB; s++) b.data[s*BPS +: 4] = nib[bb*SPB + s];
      pkt_q.push_back(b);
    end
    if (ctrl_open) exp_ne++;
    ctrl_open = trunc;
    if (!trunc) begin
      if (npay >= NEED && w != 0 && h != 0) begin
        exp_w = w; exp_h = h; exp_il = il; exp_nv++;
      end else begin
        exp_ne++;
      end
    end
  endtask

  // rdy_mode: 0 always ready, 1 random ready.
  task automatic send_pkt(input int nmax, input int gap_pct, input int rdy_mode);
    int i, guard;
    bit acc;
    i = 0; guard = 0;
    while (i < nmax && i < pkt_q.size()) begin
      dout_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) din_valid = 1'b0;
      else begin
        din_valid = 1'b1; din_sop = pkt_q[i].sop; din_eop = pkt_q[i].eop; din_data = pkt_q[i].data;
      end
      @(negedge clk);
      acc = din_valid && din_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
      if (guard > 500) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: accepted %0d beats, required %0d", i, nmax);
        break;
      end
    end
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    $display("[TB] packet %0d: %0d beats sent, type %h", pkt_no, i, pkt_q[0].data[3:0]);
    pkt_no++;
  endtask

  task automatic idle(input int n);
    dout_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    din_valid = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din_data = 24'h000000; dout_ready = 1'b1;
    #2;
    n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready: got %b, want 0", din_ready); end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b, want 0", dout_valid); end
    n_tests++; if ({width, height, interlaced} !== 36'd0) begin n_fail++; $display("FAIL reset_fields: got w=%h h=%h i=%h, want 0", width, height, interlaced); end
    n_tests++; if ({ctrl_valid, ctrl_error} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got v=%b e=%b, want 0", ctrl_valid, ctrl_error); end
    din_valid = 1'b0; din_sop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_control();
    int nobs;
    nobs = obs_q.size();
    build_ctrl(16'd1280, 16'd720, 4'h3, 3, 1'b0);
    send_pkt(pkt_q.size(), 0, 1);
    n_tests++; if (ctrl_valid !== 1'b1) begin n_fail++; $display("FAIL ctrl_pulse: got %b, want 1", ctrl_valid); end
    n_tests++; if (width !== 16'd1280) begin n_fail++; $display("FAIL ctrl_width: got %0d, want 1280", width); end
    n_tests++; if (height !== 16'd720) begin n_fail++; $display("FAIL ctrl_height: got %0d, want 720", height); end
    n_tests++; if (interlaced !== 4'h3) begin n_fail++; $display("FAIL ctrl_interlaced: got %h, want 3", interlaced); end
    @(posedge clk); #1;
    n_tests++; if (ctrl_valid !== 1'b0) begin n_fail++; $display("FAIL ctrl_pulse_len: got %b, want 0", ctrl_valid); end
    idle(2);
    n_tests++; if (obs_q.size() != nobs) begin n_fail++; $display("FAIL ctrl_no_output: got %0d beats, want %0d", obs_q.size(), nobs); end
    n_tests++; if (cv_cnt !== exp_nv) begin n_fail++; $display("FAIL ctrl_valid_count: got %0d, want %0d", cv_cnt, exp_nv); end
    chk_idx = exp_q.size();
  endtask

  task automatic test_video_toggle();
    int i, guard;
    bit acc, tog;
    build_stream(4'h0, 8, 1'b0);
    i = 0; guard = 0; tog = 1'b1;
    while (i < 9 && guard < 100) begin
      dout_ready = tog; tog = !tog;
      din_valid = 1'b1; din_sop = pkt_q[i].sop; din_eop = pkt_q[i].eop; din_data = pkt_q[i].data;
      @(negedge clk);
      n_tests++; if (din_ready !== dout_ready) begin n_fail++; $display("FAIL video_ready: got din_ready=%b, want %b", din_ready, dout_ready); end
      acc = din_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    $display("[TB] packet %0d: %0d beats sent, toggled ready", pkt_no, i);
    pkt_no++;
    n_tests++; if (i != 9) begin n_fail++; $display("FAIL video_timeout: accepted %0d, want 9", i); end
    idle(2);
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL video_count: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    for (int k = chk_idx; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL video_beat %0d: got sop=%b eop=%b data=%h, want sop=%b eop=%b data=%h", k,
                 obs_q[k].sop, obs_q[k].eop, obs_q[k].data, exp_q[k].sop, exp_q[k].eop, exp_q[k].data);
      end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_bad_ctrl();
    build_ctrl(16'd1920, 16'd1080, 4'h1, 2, 1'b0);
    send_pkt(pkt_q.size(), 0, 1);
    n_tests++; if (ctrl_error !== 1'b1) begin n_fail++; $display("FAIL short_error: got %b, want 1", ctrl_error); end
    n_tests++; if ({width, height, interlaced} !== {exp_w, exp_h, exp_il}) begin n_fail++; $display("FAIL short_hold: got %0d/%0d/%h, want %0d/%0d/%h", width, height, interlaced, exp_w, exp_h, exp_il); end
    idle(1);
    build_ctrl(16'd800, 16'd0, 4'h2, 3, 1'b0);
    send_pkt(pkt_q.size(), 10, 1);
    n_tests++; if (ctrl_error !== 1'b1) begin n_fail++; $display("FAIL zero_h_error: got %b, want 1", ctrl_error); end
    n_tests++; if (width !== exp_w) begin n_fail++; $display("FAIL zero_h_hold: got %0d, want %0d", width, exp_w); end
    idle(1);
    build_ctrl(16'd640, 16'd480, 4'h0, 3, 1'b0);
    send_pkt(pkt_q.size(), 0, 1);
    n_tests++; if (ctrl_valid !== 1'b1) begin n_fail++; $display("FAIL vga_pulse: got %b, want 1", ctrl_valid); end
    n_tests++; if ({width, height} !== {16'd640, 16'd480}) begin n_fail++; $display("FAIL vga_size: got %0dx%0d, want 640x480", width, height); end
    idle(2);
    n_tests++; if (ce_cnt !== exp_ne || cv_cnt !== exp_nv) begin n_fail++; $display("FAIL bad_counts: got v=%0d e=%0d, want v=%0d e=%0d", cv_cnt, ce_cnt, exp_nv, exp_ne); end
  endtask

  task automatic test_abort();
    build_stream(4'h0, 3, 1'b1);
    send_pkt(pkt_q.size(), 0, 0);
    build_ctrl(16'd1920, 16'd1080, 4'h2, 3, 1'b0);
    send_pkt(pkt_q.size(), 0, 1);
    build_stream(4'h0, 2, 1'b0);
    send_pkt(pkt_q.size(), 0, 1);
    build_ctrl(16'd1024, 16'd768, 4'h1, 1, 1'b1);
    send_pkt(pkt_q.size(), 0, 1);
    build_stream(4'h0, 2, 1'b0);
    send_pkt(pkt_q.size(), 0, 1);
    idle(3);
    n_tests++; if ({width, height, interlaced} !== {16'd1920, 16'd1080, 4'h2}) begin n_fail++; $display("FAIL abort_fields: got %0d/%0d/%h, want 1920/1080/2", width, height, interlaced); end
    n_tests++; if (ce_cnt !== exp_ne || cv_cnt !== exp_nv) begin n_fail++; $display("FAIL abort_counts: got v=%0d e=%0d, want v=%0d e=%0d", cv_cnt, ce_cnt, exp_nv, exp_ne); end
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL abort_count: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    for (int k = chk_idx; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL abort_beat %0d: got %h, want %h", k, obs_q[k], exp_q[k]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_other();
    build_stream(4'h3, 3, 1'b0);
    send_pkt(pkt_q.size(), 0, 1);
    idle(2);
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL other_count: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    for (int k = chk_idx; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL other_beat %0d: got %h, want %h", k, obs_q[k], exp_q[k]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_random();
    bit prev_tr, tr;
    int kind, npay;
    logic [15:0] w, h;
    beat_t sb;
    prev_tr = 1'b0;
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 9);
      tr = (p < 39) && ($urandom_range(0, 5) == 0);
      if (!prev_tr && $urandom_range(0, 4) == 0) begin
        pkt_q.delete();
        sb.sop = 1'b0; sb.eop = 1'($urandom); sb.data = DW'($urandom);
        pkt_q.push_back(sb);
        send_pkt(1, 0, 1);
      end
      if (kind < 4) build_stream(4'h0, $urandom_range(0, 6), tr);
      else if (kind < 7) begin
        w = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
        h = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
        npay = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : NEED;
        build_ctrl(w, h, 4'($urandom), npay, tr);
      end else build_stream(4'($urandom_range(1, 14)), $urandom_range(0, 5), tr);
      send_pkt(pkt_q.size(), 20, 1);
      prev_tr = tr;
    end
    idle(3);
    n_tests++; if ({width, height, interlaced} !== {exp_w, exp_h, exp_il}) begin n_fail++; $display("FAIL rand_fields: got %h/%h/%h, want %h/%h/%h", width, height, interlaced, exp_w, exp_h, exp_il); end
    n_tests++; if (cv_cnt !== exp_nv) begin n_fail++; $display("FAIL rand_valid_count: got %0d, want %0d", cv_cnt, exp_nv); end
    n_tests++; if (ce_cnt !== exp_ne) begin n_fail++; $display("FAIL rand_error_count: got %0d, want %0d", ce_cnt, exp_ne); end
    n_tests++; if (both_seen !== 1'b0) begin n_fail++; $display("FAIL rand_exclusive: got both pulses together, want never"); end
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    for (int k = chk_idx; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_beat %0d: got %h, want %h", k, obs_q[k], exp_q[k]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_reset_mid();
    build_stream(4'h3, 3, 1'b0);
    send_pkt(2, 0, 0);
    if (passes(4'h3)) begin
      void'(exp_q.pop_back());
      void'(exp_q.pop_back());
    end
    din_valid = 1'b1; din_sop = 1'b0; din_eop = 1'b0; din_data = pkt_q[2].data; dout_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    exp_w = '0; exp_h = '0; exp_il = '0; ctrl_open = 1'b0;
    n_tests++; if (width !== 16'd0) begin n_fail++; $display("FAIL midrst_width: got %0d, want 0", width); end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_dout_valid: got %b, want 0", dout_valid); end
    n_tests++; if (din_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_din_ready: got %b, want 0", din_ready); end
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    void'(pkt_q.pop_front());
    void'(pkt_q.pop_front());
    send_pkt(pkt_q.size(), 0, 1);
    build_stream(4'h0, 3, 1'b0);
    send_pkt(pkt_q.size(), 0, 1);
    idle(2);
    n_tests++; if ({width, height, interlaced} !== 36'd0) begin n_fail++; $display("FAIL midrst_fields: got %h/%h/%h, want 0", width, height, interlaced); end
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL midrst_count: got %0d beats, want %0d", obs_q.size(), exp_q.size()); end
    for (int k = chk_idx; k < exp_q.size() && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL midrst_beat %0d: got %h, want %h", k, obs_q[k], exp_q[k]); end
    end
    chk_idx = exp_q.size();
  endtask

  initial begin
    test_reset();
    test_control();
    test_video_toggle();
    test_bad_ctrl();
    test_abort();
    test_other();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
